// File: rtl/axil_sum_exerciser.sv
// AXI4-Lite master that writes an operand pair to VALUE_1/VALUE_2 of the debug
// register slave, reads SUM back and tallies matches, bus errors and timeouts.
module axil_sum_exerciser #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [31:0] iterations,
  output logic        busy,
  output logic        done,
  output logic [31:0] pass_count,
  output logic [31:0] fail_count,
  output logic [1:0]  error,
  output logic [31:0] last_sum,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic [31:0] M_AXI_RDATA,
  input  logic        M_AXI_RVALID,
  input  logic [1:0]  M_AXI_RRESP,
  output logic        M_AXI_RREADY
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WR1    = 4'd1;
  localparam logic [3:0] S_WR1_B  = 4'd2;
  localparam logic [3:0] S_WR2    = 4'd3;
  localparam logic [3:0] S_WR2_B  = 4'd4;
  localparam logic [3:0] S_RD     = 4'd5;
  localparam logic [3:0] S_RD_R   = 4'd6;
  localparam logic [3:0] S_CHECK  = 4'd7;
  localparam logic [3:0] S_FINISH = 4'd8;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_RESP    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic [31:0] swap_halves(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  logic [3:0]    state;
  logic [31:0]   v1;
  logic [31:0]   v2;
  logic [31:0]   expected;
  logic [31:0]   iter_total;
  logic [31:0]   iter_idx;
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic          aw_left;
  logic          w_left;
  logic          last_iter;
  logic          awvalid;
  logic          wvalid;
  logic          bready;
  logic          arvalid;
  logic          rready;

  assign v2        = swap_halves(v1);
  assign expected  = v1 + v2;
  assign tmo       = (tcnt == TMO_LAST);
  assign aw_left   = awvalid & ~M_AXI_AWREADY;
  assign w_left    = wvalid & ~M_AXI_WREADY;
  assign last_iter = (iter_idx + 32'd1 == iter_total);

  assign busy = (state != S_IDLE) && (state != S_FINISH);
  assign done = (state == S_FINISH);

  assign M_AXI_AWADDR  = BASE_ADDR + ((state == S_WR2) ? 32'h10 : 32'h0C);
  assign M_AXI_WDATA   = (state == S_WR2) ? v2 : v1;
  assign M_AXI_ARADDR  = BASE_ADDR + 32'h14;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;

  // Operand generation: v1 = seed + i, advanced once per completed iteration.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      v1         <= seed;
      iter_total <= iterations;
    end else if (state == S_CHECK && !last_iter) begin
      v1 <= v1 + 32'd1;
    end
  end

  // Control FSM; tcnt free-runs and is zeroed whenever a bus state is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      pass_count <= 32'd0;
      fail_count <= 32'd0;
      error      <= 2'd0;
      last_sum   <= 32'd0;
      iter_idx   <= 32'd0;
      tcnt       <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            pass_count <= 32'd0;
            fail_count <= 32'd0;
            error      <= 2'd0;
            last_sum   <= 32'd0;
            iter_idx   <= 32'd0;
            if (iterations == 32'd0) begin
              state <= S_FINISH;
            end else begin
              state   <= S_WR1;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              tcnt    <= '0;
            end
          end
        end
        S_WR1, S_WR2: begin
          if (awvalid && M_AXI_AWREADY) awvalid <= 1'b0;
          if (wvalid && M_AXI_WREADY)   wvalid  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready <= 1'b1;
            tcnt   <= '0;
            state  <= (state == S_WR1) ? S_WR1_B : S_WR2_B;
          end else if (tmo) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            error   <= ERR_TIMEOUT;
            state   <= S_FINISH;
          end
        end
        S_WR1_B, S_WR2_B: begin
          if (bready && M_AXI_BVALID) begin
            bready <= 1'b0;
            tcnt   <= '0;
            if (M_AXI_BRESP != 2'b00) begin
              error <= ERR_RESP;
              state <= S_FINISH;
            end else if (state == S_WR1_B) begin
              state   <= S_WR2;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= S_RD;
              arvalid <= 1'b1;
            end
          end else if (tmo) begin
            bready <= 1'b0;
            error  <= ERR_TIMEOUT;
            state  <= S_FINISH;
          end
        end
        S_RD: begin
          if (arvalid && M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            tcnt    <= '0;
            state   <= S_RD_R;
          end else if (tmo) begin
            arvalid <= 1'b0;
            error   <= ERR_TIMEOUT;
            state   <= S_FINISH;
          end
        end
        S_RD_R: begin
          if (rready && M_AXI_RVALID) begin
            rready   <= 1'b0;
            last_sum <= M_AXI_RDATA;
            if (M_AXI_RRESP != 2'b00) begin
              error <= ERR_RESP;
              state <= S_FINISH;
            end else begin
              state <= S_CHECK;
            end
          end else if (tmo) begin
            rready <= 1'b0;
            error  <= ERR_TIMEOUT;
            state  <= S_FINISH;
          end
        end
        S_CHECK: begin
          if (last_sum == expected) pass_count <= pass_count + 32'd1;
          else                      fail_count <= fail_count + 32'd1;
          if (last_iter) begin
            state <= S_FINISH;
          end else begin
            iter_idx <= iter_idx + 32'd1;
            state    <= S_WR1;
            awvalid  <= 1'b1;
            wvalid   <= 1'b1;
            tcnt     <= '0;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sum_exerciser.sv
// Bench for axil_sum_exerciser: configurable register-slave model, queue-based
// scoreboard fed by a spec-level reference model, and a negedge monitor.
module tb_axil_sum_exerciser;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = 32'd0;
  logic [31:0] iterations = 32'd0;
  logic        busy, done;
  logic [31:0] pass_count, fail_count, last_sum;
  logic [1:0]  error;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  always #5 clk = ~clk;

  axil_sum_exerciser #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .iterations(iterations),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .error(error), .last_sum(last_sum),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] pass; logic [31:0] fail; logic [1:0] err; logic [31:0] last; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  // Slave configuration, written by the stimulus process only.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit ar_never = 1'b0;
  int bad_wr_abs = -1, bad_rd_abs = -1;
  int wr_cnt = 0, rd_cnt = 0;

  // Register-file slave: VALUE_1 at index 3, VALUE_2 at index 4, SUM at index 5.
  int          aw_c, w_c, ar_c, b_c, r_c;
  bit          have_aw, have_w, have_ar;
  logic [31:0] s_awaddr, s_wdata, reg3, reg4, widx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      M_AXI_AWREADY <= 1'b0; M_AXI_WREADY <= 1'b0; M_AXI_BVALID <= 1'b0;
      M_AXI_BRESP <= 2'b00; M_AXI_ARREADY <= 1'b0; M_AXI_RVALID <= 1'b0;
      M_AXI_RDATA <= 32'd0; M_AXI_RRESP <= 2'b00;
      aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
      have_aw = 0; have_w = 0; have_ar = 0;
    end else begin
      if (M_AXI_AWREADY && M_AXI_AWVALID) begin
        M_AXI_AWREADY <= 1'b0; have_aw = 1; s_awaddr = M_AXI_AWADDR; aw_c = 0;
      end else if (!have_aw && !M_AXI_AWREADY) begin
        if (aw_c >= aw_dly) M_AXI_AWREADY <= 1'b1;
        else if (M_AXI_AWVALID) aw_c++;
      end
      if (M_AXI_WREADY && M_AXI_WVALID) begin
        M_AXI_WREADY <= 1'b0; have_w = 1; s_wdata = M_AXI_WDATA; w_c = 0;
      end else if (!have_w && !M_AXI_WREADY) begin
        if (w_c >= w_dly) M_AXI_WREADY <= 1'b1;
        else if (M_AXI_WVALID) w_c++;
      end
      if (have_aw && have_w && !M_AXI_BVALID) begin
        if (b_c >= b_dly) begin
          M_AXI_BVALID <= 1'b1;
          if (wr_cnt == bad_wr_abs) begin
            M_AXI_BRESP <= 2'b11;
          end else begin
            M_AXI_BRESP <= 2'b00;
            widx = (s_awaddr - BASE) >> 2;
            if (widx == 32'd3) reg3 = s_wdata;
            if (widx == 32'd4) reg4 = s_wdata;
          end
          wr_cnt++; b_c = 0;
        end else b_c++;
      end else if (M_AXI_BVALID && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b0; have_aw = 0; have_w = 0;
      end
      if (M_AXI_ARREADY && M_AXI_ARVALID) begin
        M_AXI_ARREADY <= 1'b0; have_ar = 1; ar_c = 0;
      end else if (ar_never) begin
        M_AXI_ARREADY <= 1'b0;
      end else if (!have_ar && !M_AXI_ARREADY) begin
        if (ar_c >= ar_dly) M_AXI_ARREADY <= 1'b1;
        else if (M_AXI_ARVALID) ar_c++;
      end
      if (have_ar && !M_AXI_RVALID) begin
        if (r_c >= r_dly) begin
          M_AXI_RVALID <= 1'b1;
          M_AXI_RDATA  <= reg3 + reg4 + ((rd_cnt == bad_rd_abs) ? 32'd1 : 32'd0);
          M_AXI_RRESP  <= 2'b00;
          rd_cnt++; r_c = 0;
        end else r_c++;
      end else if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0; have_ar = 0;
      end
    end
  end

  // Monitor: samples between edges, pops the scoreboard on each completed
  // write pair and on each done pulse.
  logic [31:0] m_awaddr, m_wdata;
  bit m_have_aw = 0, m_have_w = 0, mon_ignore = 0, prev_done = 0;
  int ar_cycles = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_have_aw = 0; m_have_w = 0; prev_done = 0;
    end else begin
      if (M_AXI_ARVALID) ar_cycles++;
      if (!mon_ignore) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          check32("aw_no_duplicate", 32'(m_have_aw), 32'd0);
          check32("awprot", 32'(M_AXI_AWPROT), 32'd0);
          m_awaddr = M_AXI_AWADDR; m_have_aw = 1;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          check32("w_no_duplicate", 32'(m_have_w), 32'd0);
          check32("wstrb", 32'(M_AXI_WSTRB), 32'hF);
          m_wdata = M_AXI_WDATA; m_have_w = 1;
        end
        if (m_have_aw && m_have_w) begin
          if (wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", m_awaddr, m_wdata);
          end else begin
            wr_t e;
            e = wr_q.pop_front();
            check32("wr_addr", m_awaddr, e.addr);
            check32("wr_data", m_wdata, e.data);
          end
          m_have_aw = 0; m_have_w = 0;
        end
        if (M_AXI_BVALID && M_AXI_BREADY)
          check32("valids_low_during_b", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          check32("ar_addr", M_AXI_ARADDR, BASE + 32'h14);
          check32("arprot", 32'(M_AXI_ARPROT), 32'd0);
        end
        if (done) begin
          check32("done_one_cycle", 32'(prev_done), 32'd0);
          check32("busy_low_at_done", 32'(busy), 32'd0);
          if (res_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done: got done pulse, none expected");
          end else begin
            res_t r;
            r = res_q.pop_front();
            check32("pass_count", pass_count, r.pass);
            check32("fail_count", fail_count, r.fail);
            check32("error", 32'(error), 32'(r.err));
            check32("last_sum", last_sum, r.last);
          end
        end
      end
      prev_done = done;
    end
  end

  // Reference model: walks the iterations with plain arithmetic and queues the
  // expected write beats and final report.
  task automatic model_push(input logic [31:0] s, input int n, input int bad, input int corrupt,
                            input bit arn);
    logic [31:0] v1, v2, sum, rd;
    wr_t  w;
    res_t r;
    r.pass = 0; r.fail = 0; r.err = 2'd0; r.last = 0;
    for (int i = 0; i < n; i++) begin
      v1  = s + 32'(i);
      v2  = (v1 << 16) | (v1 >> 16);
      sum = v1 + v2;
      w.addr = BASE + 32'd12; w.data = v1; wr_q.push_back(w);
      if (bad == 2 * i) begin r.err = 2'd1; break; end
      w.addr = BASE + 32'd16; w.data = v2; wr_q.push_back(w);
      if (bad == 2 * i + 1) begin r.err = 2'd1; break; end
      if (arn) begin r.err = 2'd2; break; end
      rd = (i == corrupt) ? sum + 32'd1 : sum;
      r.last = rd;
      if (rd == sum) r.pass++; else r.fail++;
    end
    res_q.push_back(r);
  endtask

  task automatic run(input logic [31:0] s, input int n, input int bad, input int corrupt,
                     input bit arn, input int awd, input int wd, input int ard, input int bd,
                     input int rdd, input bit poke_start);
    aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rdd; ar_never = arn;
    bad_wr_abs = (bad < 0) ? -1 : wr_cnt + bad;
    bad_rd_abs = (corrupt < 0) ? -1 : rd_cnt + corrupt;
    model_push(s, n, bad, corrupt, arn);
    @(posedge clk); #1;
    seed = s; iterations = 32'(n); start = 1'b1; ar_cycles = 0;
    @(posedge clk); #1;
    start = 1'b0; seed = $urandom; iterations = $urandom_range(1, 50);
    if (n > 0) check32("busy_after_start", 32'(busy), 32'd1);
    if (poke_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int c = 0; c < 4000 && res_q.size() != 0; c++) @(posedge clk);
    if (res_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL run_timeout: done not seen within 4000 cycles, %0d writes pending", wr_q.size());
      res_q.delete(); wr_q.delete();
    end else begin
      check32("writes_consumed", 32'(wr_q.size()), 32'd0);
    end
    if (arn) check32("arvalid_cycles", 32'(ar_cycles), 32'(TMO));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, bad, cor;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_valids", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    check32("rst_pass", pass_count, 32'd0);
    check32("rst_error", 32'(error), 32'd0);
    check32("rst_last_sum", last_sum, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run(32'h0000_0001, 1, -1, -1, 0, 0, 0, 0, 0, 0, 0);
    run(32'hFFFF_FFFF, 2, -1, -1, 0, 0, 0, 0, 0, 0, 0);
    run($urandom, 3, -1, -1, 0, 5, 0, 0, 1, 1, 0);
    run($urandom, 3, -1, -1, 0, 0, 5, 2, 0, 2, 0);
    run($urandom, 3, -1, 1, 0, 0, 0, 0, 0, 0, 0);
    run($urandom, 3, 1, -1, 0, 0, 0, 0, 0, 0, 0);
    run($urandom, 2, -1, -1, 1, 0, 0, 0, 0, 0, 0);
    run($urandom, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0);
    run($urandom, 4, -1, -1, 0, 1, 2, 1, 1, 1, 1);

    for (int k = 0; k < 10; k++) begin
      n   = $urandom_range(1, 5);
      cor = int'($urandom_range(0, n)) - 1;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
      run($urandom, n, bad, cor, 0, $urandom_range(0, 6), $urandom_range(0, 6),
          $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4), 0);
    end

    // Asynchronous reset in the middle of a long run.
    mon_ignore = 1'b1;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; ar_never = 0;
    bad_wr_abs = -1; bad_rd_abs = -1;
    @(posedge clk); #1;
    seed = $urandom; iterations = 32'd20; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check32("midrst_busy", 32'(busy), 32'd0);
    check32("midrst_done", 32'(done), 32'd0);
    check32("midrst_valids", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    check32("midrst_pass", pass_count, 32'd0);
    check32("midrst_fail", fail_count, 32'd0);
    check32("midrst_error", 32'(error), 32'd0);
    check32("midrst_last_sum", last_sum, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_ignore = 1'b0;
    begin
      int dones = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (done) dones++;
      end
      check32("no_done_after_reset", 32'(dones), 32'd0);
      check32("idle_after_reset", 32'(busy), 32'd0);
    end

    run(32'h1234_5678, 2, -1, -1, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_sum_exerciser.md
Name: axil_sum_exerciser

Overview:
- AXI4-Lite master that sits directly upstream of the debug register slave.
- Each iteration writes a generated operand pair to VALUE_1 (index 3) and VALUE_2 (index 4), then reads SUM (index 5) and compares it against the locally computed sum.
- Used in cable test to prove the AXI path end-to-end; accumulates pass/fail counts and reports the first bus error or timeout.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of register index 0 on the target slave.
- TIMEOUT, 1024, maximum cycles any single AXI transaction may take before it is aborted.

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a run; ignored while busy
- seed  in  32  operand seed, sampled on start
- iterations  in  32  number of iterations, sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run
- pass_count  out  32  iterations whose SUM matched
- fail_count  out  32  iterations whose SUM mismatched
- error  out  2  0=none, 1=BRESP/RRESP not OKAY, 2=timeout
- last_sum  out  32  most recent RDATA from SUM
- M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWPROT out 3 (tied 0)
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4 (tied 4'hF), M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_ARPROT out 3 (tied 0)
- M_AXI_RDATA in 32, M_AXI_RVALID in 1, M_AXI_RRESP in 2, M_AXI_RREADY out 1

Behaviour:
- Reset (async, high): state IDLE; all VALIDs, BREADY, RREADY, busy, done = 0; counts, error, last_sum = 0.
- Operands for iteration i (0-based), all mod 2^32: v1 = seed + i; v2 = {v1[15:0], v1[31:16]}; expected = v1 + v2, carry discarded.
- States: IDLE -> WR1 -> WR1_B -> WR2 -> WR2_B -> RD -> RD_R -> CHECK -> (WR1 or FINISH) -> IDLE.
- IDLE, start=1:
  - Latch seed and iterations; clear counts, error and last_sum.
  - iterations==0: go directly to FINISH.
  - Otherwise go to WR1.
- WRx:
  - AWVALID and WVALID rise together in the cycle after entry.
  - Each drops independently on its own handshake (VALID&READY). AW before W, W before AW, and same-cycle acceptance are all legal.
  - When both handshakes are complete, go to WRx_B with BREADY=1.
  - Addresses: BASE_ADDR+0x0C (WR1, WDATA=v1) and BASE_ADDR+0x10 (WR2, WDATA=v2).
- WRx_B: BVALID&BREADY completes the write; BRESP!=0 sets error=1 and goes to FINISH.
- RD: ARVALID=1 with ARADDR=BASE_ADDR+0x14; holds until ARREADY, then go to RD_R with RREADY=1.
- RD_R:
  - RVALID captures RDATA into last_sum.
  - RRESP!=0 sets error=1 and goes to FINISH.
  - Otherwise go to CHECK.
- CHECK (one cycle):
  - last_sum==expected increments pass_count; otherwise increments fail_count. A mismatch does not abort the run.
  - i+1==iterations goes to FINISH; otherwise increment i and go to WR1.
- VALID outputs never drop before their handshake unless the transaction times out or reset asserts.
- Timeout:
  - Per-state cycle counter, cleared on entry to each WR/WR_B/RD/RD_R state.
  - Reaching TIMEOUT drops all VALID/READY outputs, sets error=2 and goes to FINISH.
- FINISH: pulses done for one cycle, busy=0 in the same cycle, then IDLE. Counts, error and last_sum hold until the next start.
- start during busy: ignored; no effect on the run.
- Reset mid-transaction: outputs go to reset values immediately; no completion is issued.
- Counts cannot overflow because they never exceed iterations.

Test Plan:
- Ideal slave (always ready, OKAY), seed=0x0000_0001, iterations=1 -> writes 0x1 @0x0C and 0x0001_0000 @0x10; reads 0x14; slave returns 0x0001_0001 -> pass=1, fail=0, error=0, done one pulse.
- seed=0xFFFF_FFFF, iterations=2 -> i=1 gives v1=0, v2=0, expected=0; i=0 gives v1=0xFFFF_FFFF, expected=0xFFFF_FFFE (carry dropped); correct slave -> pass=2.
- Slave delays AWREADY 5 cycles but accepts W immediately, and vice versa -> one B per write, no duplicate AW/W handshakes; pass counts correct.
- Slave returns SUM+1 on second of 3 iterations -> pass=2, fail=1, error=0, last_sum = iteration-2 value.
- Slave returns BRESP=2'b11 on WR2 of iteration 0 -> error=1, no AR issued, pass=fail=0, done pulse.
- Slave never asserts ARREADY, TIMEOUT=16 -> ARVALID drops after 16 cycles, error=2, done. Separately, reset mid-run zeroes all outputs, and start pulses during busy are ignored.
